// File: rtl/tdm_demux_scheduler.sv
// Round-robin TDM scheduler driving a 1-to-16 demux: SEEK picks the next enabled
// channel, DWELL accepts DWELL beats on it. Optional GUARD gap via TDM_DEMUX_GUARD_EN.
module tdm_demux_scheduler #(
  parameter int unsigned DWELL = 4,
  parameter bit          CONT  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] ch_mask,
  input  logic        din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [3:0]  sel,
  output logic [15:0] y,
  output logic        ch_done,
  output logic        frame_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEEK  = 2'd1,
    S_DWELL = 2'd2,
    S_GUARD = 2'd3
  } state_t;

`ifdef TDM_DEMUX_GUARD_EN
  localparam state_t NEXT_CH = S_GUARD;
`else
  localparam state_t NEXT_CH = S_SEEK;
`endif

  localparam logic [7:0] LAST_CNT = 8'(DWELL) - 8'd1;

  state_t      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] mask_q, mask_d;
  logic [15:0] y_q, y_d;
  logic        stop_pend_q, stop_pend_d;
  logic        empty_done_q, empty_done_d;

  logic beat_s;
  logic last_beat_s;
  logic has_above_s;
  logic stop_eff_s;

  // Lowest enabled index at or above the search pointer.
  function automatic logic [3:0] first_from(input logic [15:0] m, input logic [3:0] p);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i] && (i >= int'(p))) begin
        r = 4'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sel_q        <= 4'd0;
      ptr_q        <= 4'd0;
      cnt_q        <= 8'd0;
      mask_q       <= 16'h0000;
      y_q          <= 16'h0000;
      stop_pend_q  <= 1'b0;
      empty_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      y_q          <= y_d;
      stop_pend_q  <= stop_pend_d;
      empty_done_q <= empty_done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    stop_pend_d  = stop_pend_q;
    empty_done_d = 1'b0;
    y_d          = beat_s ? ({15'd0, din} << sel_q) : 16'h0000;
    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        cnt_d       = 8'd0;
        if (start && (ch_mask != 16'h0000)) begin
          mask_d  = ch_mask;
          ptr_d   = 4'd0;
          state_d = S_SEEK;
        end else if (start) begin
          empty_done_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEEK: begin
        sel_d       = first_from(mask_q, ptr_q);
        state_d     = S_DWELL;
        stop_pend_d = stop_pend_q | stop;
      end
      S_DWELL: begin
        stop_pend_d = stop_pend_q | stop;
        if (last_beat_s) begin
          cnt_d = 8'd0;
          if (stop_eff_s) begin
            stop_pend_d = 1'b0;
            state_d     = S_IDLE;
          end else if (has_above_s) begin
            ptr_d   = sel_q + 4'd1;
            state_d = NEXT_CH;
          end else if (CONT) begin
            ptr_d   = 4'd0;
            state_d = NEXT_CH;
          end else begin
            state_d = S_IDLE;
          end
        end else if (beat_s) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
`ifdef TDM_DEMUX_GUARD_EN
      S_GUARD: begin
        stop_pend_d = stop_pend_q | stop;
        state_d     = S_SEEK;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake, pulses and status; ch_done is combinational on the final beat.
  always_comb begin
    din_ready   = (state_q == S_DWELL);
    busy        = (state_q != S_IDLE);
    beat_s      = din_valid & din_ready;
    last_beat_s = beat_s & (cnt_q == LAST_CNT);
    has_above_s = |(mask_q & (16'hFFFE << sel_q));
    stop_eff_s  = stop_pend_q | stop;
    ch_done     = last_beat_s;
    frame_done  = empty_done_q | (last_beat_s & ~has_above_s & ~stop_eff_s);
  end

  assign sel = sel_q;
  assign y   = y_q;

endmodule

// File: tb/tb_tdm_demux_scheduler.sv
// Bench for tdm_demux_scheduler: per-cycle vector tables plus a y scoreboard,
// with two instances (CONT=0 and CONT=1) sharing the stimulus.
module tb_tdm_demux_scheduler;

`ifdef TDM_DEMUX_GUARD_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 1;
`endif

  typedef struct {
    logic        start;
    logic        stop;
    logic [15:0] mask;
    logic        din;
    logic        vld;
    logic        rdy;
    logic [3:0]  sel;
    logic        cd;
    logic        fd;
    logic        busy;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] ch_mask;
  logic        din;
  logic        din_valid;

  logic        r0_rdy, r1_rdy, r0_cd, r1_cd, r0_fd, r1_fd, r0_busy, r1_busy;
  logic [3:0]  r0_sel, r1_sel;
  logic [15:0] r0_y, r1_y;

  logic        which;
  logic        o_rdy, o_cd, o_fd, o_busy;
  logic [3:0]  o_sel;
  logic [15:0] o_y;

  int          checks;
  int          failures;
  vec_t        tbl[$];
  logic [15:0] sb[$];

  tdm_demux_scheduler #(.DWELL(4), .CONT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ch_mask(ch_mask),
    .din(din), .din_valid(din_valid), .din_ready(r0_rdy), .sel(r0_sel), .y(r0_y),
    .ch_done(r0_cd), .frame_done(r0_fd), .busy(r0_busy)
  );

  tdm_demux_scheduler #(.DWELL(4), .CONT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ch_mask(ch_mask),
    .din(din), .din_valid(din_valid), .din_ready(r1_rdy), .sel(r1_sel), .y(r1_y),
    .ch_done(r1_cd), .frame_done(r1_fd), .busy(r1_busy)
  );

  always_comb begin
    o_rdy  = which ? r1_rdy  : r0_rdy;
    o_sel  = which ? r1_sel  : r0_sel;
    o_y    = which ? r1_y    : r0_y;
    o_cd   = which ? r1_cd   : r0_cd;
    o_fd   = which ? r1_fd   : r0_fd;
    o_busy = which ? r1_busy : r0_busy;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic sp, input logic [15:0] m, input logic d,
                     input logic v, input logic rdy, input logic [3:0] s, input logic cd,
                     input logic fd, input logic bz);
    vec_t e;
    e.start = st; e.stop = sp; e.mask = m; e.din = d; e.vld = v;
    e.rdy = rdy; e.sel = s; e.cd = cd; e.fd = fd; e.busy = bz;
    tbl.push_back(e);
  endtask

  // Apply one vector: drive after the rising edge, compare on the falling edge.
  task automatic step(input vec_t v, input string tag);
    logic [15:0] exp_y;
    start = v.start; stop = v.stop; ch_mask = v.mask; din = v.din; din_valid = v.vld;
    @(negedge clk);
    chk({tag, ".rdy"},  {31'd0, o_rdy},  {31'd0, v.rdy});
    chk({tag, ".sel"},  {28'd0, o_sel},  {28'd0, v.sel});
    chk({tag, ".cd"},   {31'd0, o_cd},   {31'd0, v.cd});
    chk({tag, ".fd"},   {31'd0, o_fd},   {31'd0, v.fd});
    chk({tag, ".busy"}, {31'd0, o_busy}, {31'd0, v.busy});
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp_y = sb.pop_front();
      chk({tag, ".y"}, {16'd0, o_y}, {16'd0, exp_y});
    end
    sb.push_back((v.vld && v.rdy) ? ({15'd0, v.din} << v.sel) : 16'h0000);
    @(posedge clk); #1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("%s[%0d]", tag, i));
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    start = 1'b0; stop = 1'b0; ch_mask = 16'h0000; din = 1'b0; din_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    sb.push_back(16'h0000);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rdy"},  {31'd0, o_rdy},  32'd0);
    chk({tag, ".sel"},  {28'd0, o_sel},  32'd0);
    chk({tag, ".y"},    {16'd0, o_y},    32'd0);
    chk({tag, ".cd"},   {31'd0, o_cd},   32'd0);
    chk({tag, ".fd"},   {31'd0, o_fd},   32'd0);
    chk({tag, ".busy"}, {31'd0, o_busy},32'd0);
  endtask

  initial begin
    int n;
    int gap;
    checks = 0; failures = 0; which = 1'b0;
    start = 1'b0; stop = 1'b0; ch_mask = 16'h0000; din = 1'b0; din_valid = 1'b0;
    rst_n = 1'b0;
    do_reset();
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;

    // Two channels, continuous valid; mask/start changes mid-frame must be ignored.
    add(1'b1, 1'b0, 16'h1008, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h1008, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'h1008, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'h1008, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'h1008, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
    if (GAP == 2) add(1'b0, 1'b0, 16'h1008, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'h1008, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'h1008, 1'b1, 1'b1, 1'b1, 4'd12, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 16'h1008, 1'b1, 1'b1, 1'b1, 4'd12, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'h1008, 1'b1, 1'b1, 1'b1, 4'd12, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'h1008, 1'b1, 1'b1, 1'b1, 4'd12, 1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b0, 16'h1008, 1'b0, 1'b0, 1'b0, 4'd12, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h1008, 1'b0, 1'b0, 1'b0, 4'd12, 1'b0, 1'b0, 1'b0);
    run_table("two_ch");

    // Empty mask: frame_done one cycle later, never busy, sel held.
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd12, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd12, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd12, 1'b0, 1'b0, 1'b0);
    run_table("empty");

    // Gappy valid: only accepted beats count; random data through the scoreboard.
    add(1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 4'd12, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 4'd12, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      add(1'b0, 1'b0, 16'h0003, 1'($urandom_range(0, 1)), ((k % 2) == 0), 1'b1, 4'd0,
          (k == 6), 1'b0, 1'b1);
    end
    if (GAP == 2) add(1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      add(1'b0, 1'b0, 16'h0003, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 4'd1,
          (k == 3), (k == 3), 1'b1);
    end
    add(1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    run_table("gappy");

    // Reset asserted mid-dwell with a beat pending in y.
    add(1'b1, 1'b0, 16'h0004, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h0004, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'h0004, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'h0004, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
    run_table("pre_rst");
    rst_n = 1'b0; din_valid = 1'b0; start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk_all_zero($sformatf("mid_rst[%0d]", k));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst.busy", {31'd0, o_busy}, 32'd0);
    chk("post_rst.rdy",  {31'd0, o_rdy},  32'd0);
    sb.delete();
    sb.push_back(16'h0000);

    // CONT=1 instance: automatic restart, then stop during a dwell.
    which = 1'b1;
    add(1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      add(1'b0, 1'b0, 16'h0001, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 4'd0,
          (k == 3), (k == 3), 1'b1);
    end
    if (GAP == 2) add(1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      add(1'b0, (k == 0), 16'h0001, 1'b1, 1'b1, 1'b1, 4'd0, (k == 3), 1'b0, 1'b1);
    end
    add(1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 16'h8001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h8001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      add(1'b0, (k == 0), 16'h8001, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 4'd0,
          (k == 3), 1'b0, 1'b1);
    end
    add(1'b0, 1'b0, 16'h8001, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h8001, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    run_table("cont_stop");

    // Channel-to-channel gap between channels 1 and 2.
    which = 1'b0;
    do_reset();
    start = 1'b1; ch_mask = 16'h0006; din = 1'b1; din_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!o_rdy && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("gap.first_ready", {31'd0, o_rdy}, 32'd1);
    chk("gap.sel_a", {28'd0, o_sel}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("gap.cd_a[%0d]", k), {31'd0, o_cd}, (k == 3) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    gap = 0;
    while (!o_rdy && gap < 10) begin
      gap++;
      @(posedge clk); #1;
    end
    chk("gap.cycles", gap, GAP);
    chk("gap.sel_b", {28'd0, o_sel}, 32'd2);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("gap.fd_b[%0d]", k), {31'd0, o_fd}, (k == 3) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    n = 0;
    while (o_busy && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("gap.idle", {31'd0, o_busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
